// File: rtl/sync_pkg.sv
// Shared types and timing constants for the calibration sync generator
// and the calibration FSM that consumes its fronts.
package sync_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FG_HIGH = 3'd1,
        S_FG_GAP  = 3'd2,
        S_PH_HIGH = 3'd3,
        S_PH_LOW  = 3'd4,
        S_DONE    = 3'd5
    } gen_state_t;

    localparam int unsigned CLK_PERIOD_NS = 5;

    // 9 ms frame-grabber delay at 200 MHz
    localparam int unsigned FG_DELAY_CYC    = 1_800_000;
    localparam int unsigned PHASE_SHIFT_CYC = 140;
    localparam int unsigned TRIG_LEN_CYC    = 20;

    localparam int unsigned DEF_FG_WIDTH     = 100;
    localparam int unsigned DEF_FG_GAP       = 2_000_000;
    localparam int unsigned DEF_PHASE_WIDTH  = 200;
    localparam int unsigned DEF_PHASE_PERIOD = 20_000;
    localparam int unsigned DEF_N_PHASES     = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/sync_pattern_gen_rise_detect.sv
// Rising-edge detector: two-bit input history plus a registered edge flag,
// giving a fixed two-cycle input-to-edge latency.
module rise_detect (
    input  logic clock,
    input  logic reset_signal,
    input  logic sig,
    output logic rise
);

    logic [1:0] hist_q, hist_d;
    logic       rise_q, rise_d;

    always_comb begin
        hist_d = {hist_q[0], sig};
        rise_d = (hist_q == 2'b01);
    end

    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            hist_q <= 2'b00;
            rise_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sync_pattern_gen.sv
// Loopback source of the frame-grabber pulse and the phase-front train
// driving the calibration FSM.
module sync_pattern_gen
    import sync_pkg::*;
#(
    parameter int unsigned FG_WIDTH     = DEF_FG_WIDTH,
    parameter int unsigned FG_GAP       = DEF_FG_GAP,
    parameter int unsigned PHASE_WIDTH  = DEF_PHASE_WIDTH,
    parameter int unsigned PHASE_PERIOD = DEF_PHASE_PERIOD,
    parameter int unsigned N_PHASES     = DEF_N_PHASES
) (
    input  logic        clock,
    input  logic        reset_signal,
    input  logic        start_signal,
    input  logic        stop_signal,
    output logic        fg_signal,
    output logic        phase_signal,
    output logic        busy,
    output logic        done,
    output logic [2:0]  gen_state,
    output logic [31:0] phase_count
);

    // Counter loads hold-1 on entry; leaving on zero makes each hold exact
    localparam logic [31:0] FG_HI_LD = 32'(FG_WIDTH - 1);
    localparam logic [31:0] FG_GP_LD = 32'(FG_GAP - 1);
    localparam logic [31:0] PH_HI_LD = 32'(PHASE_WIDTH - 1);
    localparam logic [31:0] PH_LO_LD = 32'(PHASE_PERIOD - PHASE_WIDTH - 1);
    localparam logic [31:0] N_PH     = 32'(N_PHASES);

    gen_state_t  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        fg_q, fg_d;
    logic        ph_q, ph_d;
    logic        start_rise;
    logic        stop_rise;
    logic        cnt_zero;

    rise_detect u_start (
        .clock        (clock),
        .reset_signal (reset_signal),
        .sig          (start_signal),
        .rise         (start_rise)
    );

    rise_detect u_stop (
        .clock        (clock),
        .reset_signal (reset_signal),
        .sig          (stop_signal),
        .rise         (stop_rise)
    );

    assign cnt_zero = (cnt_q == 32'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        fg_d    = fg_q;
        ph_d    = ph_q;
        if (stop_rise && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
            fg_d    = 1'b0;
            ph_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_rise && !stop_rise) begin
                        state_d = S_FG_HIGH;
                        cnt_d   = FG_HI_LD;
                        pc_d    = 32'd0;
                        fg_d    = 1'b1;
                    end
                end
                S_FG_HIGH: begin
                    if (cnt_zero) begin
                        state_d = S_FG_GAP;
                        cnt_d   = FG_GP_LD;
                        fg_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                S_FG_GAP: begin
                    if (cnt_zero) begin
                        state_d = S_PH_HIGH;
                        cnt_d   = PH_HI_LD;
                        pc_d    = sat_inc(pc_q);
                        ph_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                S_PH_HIGH: begin
                    if (cnt_zero) begin
                        state_d = S_PH_LOW;
                        cnt_d   = PH_LO_LD;
                        ph_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                S_PH_LOW: begin
                    if (cnt_zero) begin
                        if (N_PH != 32'd0 && pc_q == N_PH) begin
                            state_d = S_DONE;
                            cnt_d   = 32'd0;
                        end else begin
                            state_d = S_PH_HIGH;
                            cnt_d   = PH_HI_LD;
                            pc_d    = sat_inc(pc_q);
                            ph_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                    fg_d    = 1'b0;
                    ph_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            pc_q    <= 32'd0;
            fg_q    <= 1'b0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            fg_q    <= fg_d;
            ph_q    <= ph_d;
        end
    end

    assign fg_signal    = fg_q;
    assign phase_signal = ph_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign gen_state    = state_q;
    assign phase_count  = pc_q;

endmodule
